// File: rtl/lcd_cmd_pkg.sv
// lcd_cmd_pkg: shared opcodes, timing constants, FSM state types and address helpers for lcd_cmd_engine.
package lcd_cmd_pkg;

    localparam logic [7:0] OP_CD_MASK   = 8'hFF, OP_CD_PAT   = 8'h01;
    localparam logic [7:0] OP_RCH_MASK  = 8'hFE, OP_RCH_PAT  = 8'h02;
    localparam logic [7:0] OP_EMS_MASK  = 8'hFC, OP_EMS_PAT  = 8'h04;
    localparam logic [7:0] OP_DOO_MASK  = 8'hF8, OP_DOO_PAT  = 8'h08;
    localparam logic [7:0] OP_CDS_MASK  = 8'hF0, OP_CDS_PAT  = 8'h10;
    localparam logic [7:0] OP_FS_MASK   = 8'hE0, OP_FS_PAT   = 8'h20;
    localparam logic [7:0] OP_CGRA_MASK = 8'hC0, OP_CGRA_PAT = 8'h40;
    localparam logic [7:0] OP_DDRA_MASK = 8'h80, OP_DDRA_PAT = 8'h80;

    localparam int BUSY_US_W = 11;
    localparam logic [BUSY_US_W-1:0] BUSY_CD_US  = 11'd1640;
    localparam logic [BUSY_US_W-1:0] BUSY_RCH_US = 11'd1600;
    localparam logic [BUSY_US_W-1:0] BUSY_STD_US = 11'd40;

    localparam logic [6:0] LINE0 = 7'h00;
    localparam logic [6:0] LINE1 = 7'h40;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    // Init state names the last step completed; I_DONE accepts everything.
    typedef enum logic [2:0] {I_IDLE, I_FS, I_EMS, I_DOO, I_DONE} init_t;
    typedef enum logic {R_IDLE, R_SCAN} ref_t;

    function automatic logic op_is(input logic [7:0] d, input logic [7:0] mask, input logic [7:0] pat);
        return (d & mask) == pat;
    endfunction

    function automatic logic addr_mapped(input logic [6:0] a, input int line_len);
        return int'(a) < line_len || (a >= LINE1 && int'(a) < int'(LINE1) + line_len);
    endfunction

    // Address counter step; each line wraps into the other so AC never leaves mapped space.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic id, input int line_len);
        logic [6:0] l0_end, l1_end;
        l0_end = 7'(line_len - 1);
        l1_end = 7'(int'(LINE1) + line_len - 1);
        if (id)
            return ac == l0_end ? LINE1 : ac == l1_end ? LINE0 : ac + 7'd1;
        return ac == LINE0 ? l1_end : ac == LINE1 ? l0_end : ac - 7'd1;
    endfunction

    // Rows 2/3 continue lines 0/1 one screen width further on.
    function automatic logic [6:0] vis_addr(input logic [1:0] r, input logic [5:0] c, input logic [5:0] shift,
                                            input int num_cols, input int line_len);
        int m;
        m = int'(c) + int'(shift);
        if (m >= line_len)
            m = m - line_len;
        return 7'((r[0] ? int'(LINE1) : 0) + (r[1] ? num_cols : 0) + m);
    endfunction

endpackage

// File: rtl/lcd_busy_timer.sv
// lcd_busy_timer: busy window of load_us microseconds measured in clk cycles.
//   clk, reset (async, active-high); load/load_us start a window; busy is high while it runs.
module lcd_busy_timer
    import lcd_cmd_pkg::*;
#(
    parameter int CLK_PER_US = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [BUSY_US_W-1:0] load_us,
    output logic                 busy
);

    localparam int PW = $clog2(CLK_PER_US + 1);
    localparam logic [PW-1:0] PRE_TOP = PW'(CLK_PER_US - 1);

    logic [BUSY_US_W-1:0] us_cnt;
    logic [PW-1:0]        pre;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            us_cnt <= '0;
            pre    <= '0;
        end else if (load) begin
            us_cnt <= load_us;
            pre    <= PRE_TOP;
        end else if (us_cnt != '0) begin
            pre    <= pre == '0 ? PRE_TOP : pre - 1'b1;
            us_cnt <= pre == '0 ? us_cnt - 1'b1 : us_cnt;
        end
    end

    assign busy = us_cnt != '0;

endmodule

// File: rtl/lcd_cmd_engine.sv
// lcd_cmd_engine: HD44780-style command/data engine driving per-character GUI updates.
//   clk, reset (async, active-high); strobes inst_valid/data_wr_valid/data_rd_req/bf_rd_req with data_in;
//   rd_valid/rd_data read results; char_out/row/col/char_valid GUI updates; display_on/cursor_on/blink_on;
//   busy, init_done, init_error; pulses invalid_cmd, busy_cmd, cmd_hit (one-hot accepted command).
module lcd_cmd_engine
    import lcd_cmd_pkg::*;
#(
    parameter int NUM_ROWS   = 2,
    parameter int NUM_COLS   = 16,
    parameter int CLK_PER_US = 50,
    parameter int LINE_LEN   = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       inst_valid,
    input  logic       data_wr_valid,
    input  logic       data_rd_req,
    input  logic       bf_rd_req,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic [7:0] char_out,
    output logic [1:0] row,
    output logic [5:0] col,
    output logic       char_valid,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       init_done,
    output logic       init_error,
    output logic       invalid_cmd,
    output logic       busy_cmd,
    output logic [7:0] cmd_hit
);

    if (40 * CLK_PER_US < NUM_ROWS * NUM_COLS) begin : g_bad_timing
        $error("screen refresh outlasts the shortest busy window");
    end

    logic [7:0] ddram [128];
    logic [6:0] ac;
    logic [5:0] shift, shift_inc, shift_dec, ref_c, ref_c_nx, wr_col;
    logic [1:0] ref_r, ref_r_nx, wr_row;
    logic       id, s_flag, timer_busy, scanning, wr_vis;
    init_t      init_st, init_nx;
    ref_t       ref_st, ref_nx;

    logic is_cd, is_rch, is_ems, is_doo, is_cds, is_fs, is_cgra, is_ddra;
    logic [7:0] kind;
    logic sel_inst, sel_wr, sel_rd, any, multi, go, cmd_legal, in_order;
    logic accept_inst, accept_wr, accept_rd, ref_req;
    logic [BUSY_US_W-1:0] load_us;

    assign is_cd   = op_is(data_in, OP_CD_MASK, OP_CD_PAT);
    assign is_rch  = op_is(data_in, OP_RCH_MASK, OP_RCH_PAT);
    assign is_ems  = op_is(data_in, OP_EMS_MASK, OP_EMS_PAT);
    assign is_doo  = op_is(data_in, OP_DOO_MASK, OP_DOO_PAT);
    assign is_cds  = op_is(data_in, OP_CDS_MASK, OP_CDS_PAT);
    assign is_fs   = op_is(data_in, OP_FS_MASK, OP_FS_PAT);
    assign is_cgra = op_is(data_in, OP_CGRA_MASK, OP_CGRA_PAT);
    assign is_ddra = op_is(data_in, OP_DDRA_MASK, OP_DDRA_PAT);
    assign kind    = {is_ddra, is_cgra, is_fs, is_cds, is_doo, is_ems, is_rch, is_cd};

    assign sel_inst  = inst_valid;
    assign sel_wr    = data_wr_valid & ~inst_valid;
    assign sel_rd    = data_rd_req & ~inst_valid & ~data_wr_valid;
    assign any       = inst_valid | data_wr_valid | data_rd_req;
    assign multi     = (32'(inst_valid) + 32'(data_wr_valid) + 32'(data_rd_req)) > 1;
    assign go        = any & ~busy;
    assign cmd_legal = (|kind) & (~is_fs | (data_in[3] == (NUM_ROWS > 1)))
                     & (~is_ddra | addr_mapped(data_in[6:0], LINE_LEN));
    assign in_order  = init_done | (init_st == I_IDLE & is_fs) | (init_st == I_FS & is_ems)
                     | (init_st == I_EMS & is_doo & data_in[2]) | (init_st == I_DOO & is_cd);

    assign accept_inst = go & sel_inst & cmd_legal & in_order;
    assign accept_wr   = go & sel_wr & init_done;
    assign accept_rd   = go & sel_rd & init_done;
    assign ref_req     = accept_inst & (is_cd | is_rch | (is_cds & data_in[3])) | accept_wr & s_flag;
    assign load_us     = accept_inst & is_cd ? BUSY_CD_US : accept_inst & is_rch ? BUSY_RCH_US : BUSY_STD_US;

    assign shift_inc = shift == 6'(LINE_LEN - 1) ? '0 : shift + 6'd1;
    assign shift_dec = shift == '0 ? 6'(LINE_LEN - 1) : shift - 6'd1;
    assign scanning  = ref_st == R_SCAN;
    assign busy      = timer_busy | scanning;
    assign init_done = init_st == I_DONE;

    lcd_busy_timer #(.CLK_PER_US(CLK_PER_US)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (accept_inst | accept_wr | accept_rd),
        .load_us(load_us),
        .busy   (timer_busy)
    );

    // Screen position of AC for the single-character update; the lowest row/col wins on aliases.
    always_comb begin
        wr_vis = 1'b0;
        wr_row = '0;
        wr_col = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--)
            for (int c = NUM_COLS - 1; c >= 0; c--)
                if (vis_addr(2'(r), 6'(c), shift, NUM_COLS, LINE_LEN) == ac) begin
                    wr_vis = 1'b1;
                    wr_row = 2'(r);
                    wr_col = 6'(c);
                end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_st <= I_IDLE;
            ref_st  <= R_IDLE;
            ref_r   <= '0;
            ref_c   <= '0;
        end else begin
            init_st <= init_nx;
            ref_st  <= ref_nx;
            ref_r   <= ref_r_nx;
            ref_c   <= ref_c_nx;
        end
    end

    always_comb begin
        init_nx = init_st;
        if (accept_inst && !init_done)
            init_nx = init_st == I_IDLE ? I_FS : init_st == I_FS ? I_EMS : init_st == I_EMS ? I_DOO : I_DONE;
    end

    // A new request always restarts the scan from the top-left cell.
    always_comb begin
        ref_nx   = ref_st;
        ref_r_nx = ref_r;
        ref_c_nx = ref_c;
        if (ref_req) begin
            ref_nx   = R_SCAN;
            ref_r_nx = '0;
            ref_c_nx = '0;
        end else if (scanning) begin
            ref_c_nx = ref_c == 6'(NUM_COLS - 1) ? '0 : ref_c + 6'd1;
            ref_r_nx = ref_c == 6'(NUM_COLS - 1) ? (ref_r == 2'(NUM_ROWS - 1) ? '0 : ref_r + 2'd1) : ref_r;
            ref_nx   = ref_c == 6'(NUM_COLS - 1) && ref_r == 2'(NUM_ROWS - 1) ? R_IDLE : R_SCAN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 128; i++)
                ddram[i] <= CHAR_SPACE;
            ac          <= '0;
            shift       <= '0;
            id          <= 1'b1;
            s_flag      <= 1'b0;
            display_on  <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            char_out    <= CHAR_SPACE;
            row         <= '0;
            col         <= '0;
            char_valid  <= 1'b0;
            init_error  <= 1'b0;
            invalid_cmd <= 1'b0;
            busy_cmd    <= 1'b0;
            cmd_hit     <= '0;
        end else begin
            rd_valid    <= bf_rd_req | accept_rd;
            if (bf_rd_req || accept_rd)
                rd_data <= bf_rd_req ? {busy, ac} : ddram[ac];
            invalid_cmd <= multi | (go & sel_inst & ~cmd_legal);
            busy_cmd    <= any & busy;
            cmd_hit     <= accept_inst ? kind : '0;
            init_error  <= init_error | (~init_done & go & ((sel_inst & ~(cmd_legal & in_order)) | sel_wr | sel_rd));
            char_valid  <= scanning | (accept_wr & ~s_flag & wr_vis);
            if (scanning) begin
                char_out <= ddram[vis_addr(ref_r, ref_c, shift, NUM_COLS, LINE_LEN)];
                row      <= ref_r;
                col      <= ref_c;
            end else if (accept_wr) begin
                char_out <= data_in;
                row      <= wr_row;
                col      <= wr_col;
            end
            if (accept_inst) begin
                if (is_cd) begin
                    for (int i = 0; i < 128; i++)
                        ddram[i] <= CHAR_SPACE;
                    ac    <= '0;
                    shift <= '0;
                    id    <= 1'b1;
                end
                if (is_rch) begin
                    ac    <= '0;
                    shift <= '0;
                end
                if (is_ems) begin
                    id     <= data_in[1];
                    s_flag <= data_in[0];
                end
                if (is_doo) begin
                    display_on <= data_in[2];
                    cursor_on  <= data_in[1];
                    blink_on   <= data_in[0];
                end
                if (is_cds && data_in[3])
                    shift <= data_in[2] ? shift_dec : shift_inc;
                if (is_cds && !data_in[3])
                    ac <= ac_step(ac, data_in[2], LINE_LEN);
                if (is_ddra)
                    ac <= data_in[6:0];
            end
            if (accept_wr) begin
                ddram[ac] <= data_in;
                ac        <= ac_step(ac, id, LINE_LEN);
                if (s_flag)
                    shift <= id ? shift_inc : shift_dec;
            end
            if (accept_rd)
                ac <= ac_step(ac, id, LINE_LEN);
        end
    end

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// tb_lcd_cmd_engine: directed table plus hand sequences for lcd_cmd_engine (2x16, 2 clk per us).
module tb_lcd_cmd_engine;

    localparam int CPU = 2;
    localparam int CD_CYCLES = 1640 * CPU;

    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       inst_valid = 1'b0, data_wr_valid = 1'b0, data_rd_req = 1'b0, bf_rd_req = 1'b0;
    logic       rd_valid, char_valid, display_on, cursor_on, blink_on, busy;
    logic       init_done, init_error, invalid_cmd, busy_cmd;
    logic [7:0] rd_data, char_out, cmd_hit;
    logic [1:0] row;
    logic [5:0] col;

    int checks = 0, errors = 0, cv_count = 0;

    lcd_cmd_engine #(.NUM_ROWS(2), .NUM_COLS(16), .CLK_PER_US(CPU), .LINE_LEN(40)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .inst_valid(inst_valid),
        .data_wr_valid(data_wr_valid), .data_rd_req(data_rd_req), .bf_rd_req(bf_rd_req),
        .rd_valid(rd_valid), .rd_data(rd_data), .char_out(char_out), .row(row), .col(col),
        .char_valid(char_valid), .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .busy(busy), .init_done(init_done), .init_error(init_error), .invalid_cmd(invalid_cmd),
        .busy_cmd(busy_cmd), .cmd_hit(cmd_hit)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (char_valid) cv_count++;

    typedef struct {
        logic [7:0] d;
        logic [7:0] hit;
        logic       inv;
        logic       done;
        logic [2:0] dcb;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic i, input logic w, input logic r, input logic b, input logic [7:0] d);
        inst_valid = i; data_wr_valid = w; data_rd_req = r; bf_rd_req = b; data_in = d;
        tick();
        inst_valid = 0; data_wr_valid = 0; data_rd_req = 0; bf_rd_req = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout busy=%0b", busy);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0]  = '{8'h28, 8'h20, 1'b0, 1'b0, 3'b000};
        vecs[1]  = '{8'h06, 8'h04, 1'b0, 1'b0, 3'b000};
        vecs[2]  = '{8'h0C, 8'h08, 1'b0, 1'b0, 3'b100};
        vecs[3]  = '{8'h01, 8'h01, 1'b0, 1'b1, 3'b100};
        vecs[4]  = '{8'h20, 8'h00, 1'b1, 1'b1, 3'b100};
        vecs[5]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'b100};
        vecs[6]  = '{8'h40, 8'h40, 1'b0, 1'b1, 3'b100};
        vecs[7]  = '{8'hA8, 8'h00, 1'b1, 1'b1, 3'b100};
        vecs[8]  = '{8'h02, 8'h02, 1'b0, 1'b1, 3'b100};
        vecs[9]  = '{8'h0F, 8'h08, 1'b0, 1'b1, 3'b111};
        vecs[10] = '{8'h14, 8'h10, 1'b0, 1'b1, 3'b111};
        vecs[11] = '{8'h80, 8'h80, 1'b0, 1'b1, 3'b111};

        do_reset();
        chk("rst char_out", char_out, 8'h20);
        chk("rst char_valid", char_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst init_done", init_done, 0);
        chk("rst display", {display_on, cursor_on, blink_on}, 0);
        send(0, 0, 0, 1, 8'h00);
        chk("rst bf", {rd_valid, rd_data}, 9'h100);

        send(1, 0, 0, 0, 8'h06);
        chk("early ems init_error", init_error, 1);
        chk("early ems init_done", init_done, 0);
        chk("early ems hit", cmd_hit, 0);
        chk("early ems busy", busy, 0);
        send(0, 0, 1, 0, 8'h00);
        chk("early read rd_valid", rd_valid, 0);

        do_reset();
        chk("rst2 init_error", init_error, 0);

        for (int i = 0; i < 12; i++) begin
            wait_idle();
            send(1, 0, 0, 0, vecs[i].d);
            chk($sformatf("vec%0d hit", i), cmd_hit, vecs[i].hit);
            chk($sformatf("vec%0d invalid", i), invalid_cmd, vecs[i].inv);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].hit != 0);
            chk($sformatf("vec%0d done", i), init_done, vecs[i].done);
            chk($sformatf("vec%0d dcb", i), {display_on, cursor_on, blink_on}, vecs[i].dcb);
            chk($sformatf("vec%0d init_error", i), init_error, 0);
        end

        wait_idle();
        send(1, 0, 0, 0, 8'hA7);
        wait_idle();
        send(0, 1, 0, 0, 8'h41);
        chk("wr A char_valid", char_valid, 0);
        chk("wr A busy", busy, 1);
        wait_idle();
        send(0, 1, 0, 0, 8'h42);
        chk("wr B char", {char_valid, char_out, row, col}, {1'b1, 8'h42, 2'd1, 6'd0});
        send(0, 0, 0, 1, 8'h00);
        chk("bf busy", {rd_valid, rd_data}, 9'h1C1);
        wait_idle();
        send(0, 0, 0, 1, 8'h00);
        chk("bf idle", {rd_valid, rd_data}, 9'h141);
        send(1, 0, 0, 0, 8'hA7);
        wait_idle();
        send(0, 0, 1, 0, 8'h00);
        chk("read 0x27", {rd_valid, rd_data}, 9'h141);
        wait_idle();
        send(0, 0, 1, 0, 8'h00);
        chk("read 0x40", {rd_valid, rd_data}, 9'h142);

        wait_idle();
        send(1, 0, 0, 0, 8'h01);
        cv_count = 0;
        repeat (39) tick();
        send(1, 0, 0, 0, 8'h02);
        chk("cd busy_cmd", busy_cmd, 1);
        chk("cd busy hit", cmd_hit, 0);
        repeat (CD_CYCLES - 41) tick();
        chk("cd busy last cycle", busy, 1);
        tick();
        chk("cd busy end", busy, 0);
        chk("cd refresh count", cv_count, 32);
        send(0, 0, 0, 1, 8'h00);
        chk("cd ac", rd_data, 8'h00);

        send(1, 0, 0, 0, 8'h81);
        wait_idle();
        send(0, 1, 0, 0, 8'h58);
        chk("wr X char", {char_valid, row, col}, {1'b1, 2'd0, 6'd1});
        wait_idle();
        send(1, 0, 0, 0, 8'h18);
        chk("cds hit", cmd_hit, 8'h10);
        tick();
        chk("cds first cell", {char_valid, char_out, row, col}, {1'b1, 8'h58, 2'd0, 6'd0});
        tick();
        chk("cds second cell", {char_valid, char_out, row, col}, {1'b1, 8'h20, 2'd0, 6'd1});

        wait_idle();
        send(1, 0, 0, 0, 8'h08);
        chk("doo off", display_on, 0);
        wait_idle();
        send(1, 1, 0, 0, 8'h0F);
        chk("collide hit", cmd_hit, 8'h08);
        chk("collide invalid", invalid_cmd, 1);
        chk("collide dcb", {display_on, cursor_on, blink_on}, 3'b111);
        wait_idle();
        send(0, 0, 0, 1, 8'h00);
        chk("collide ac", rd_data, 8'h02);
        send(0, 0, 1, 0, 8'h00);
        chk("collide ddram", {rd_valid, rd_data}, 9'h120);

        wait_idle();
        send(1, 0, 0, 0, 8'h02);
        repeat (3) tick();
        chk("mid refresh char_valid", char_valid, 1);
        reset = 1'b1;
        #1;
        chk("async rst char_valid", char_valid, 0);
        chk("async rst busy", busy, 0);
        chk("async rst char_out", char_out, 8'h20);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        chk("post rst char_valid", char_valid, 0);
        chk("post rst init_done", init_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
